// File: rtl/simon_pkg.sv
// Shared constants and colour type for the Simon game datapath.
package simon_pkg;

  localparam int SEQ_DEPTH = 32;
  localparam int ADDR_W    = 5;
  localparam int LEN_W     = 6;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    RED    = 2'b01,
    BLUE   = 2'b10,
    YELLOW = 2'b11
  } color_t;

endpackage

// File: rtl/seq_memory.sv
// Colour sequence store: 32 x 2-bit register file with a registered,
// write-first read port, a high-water-mark length counter and a
// one-entry-per-cycle scrub engine started by a clear pulse.
module seq_memory
  import simon_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  color_t            wr_data,
  input  logic              clear,
  output color_t            mem_data,
  output logic [LEN_W-1:0]  seq_len,
  output logic              seq_full,
  output logic              clear_busy
);

  typedef enum logic {IDLE, SCRUB} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SEQ_DEPTH - 1);
  localparam logic [LEN_W-1:0]  FULL_LEN = LEN_W'(SEQ_DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] scrub_cnt, scrub_cnt_nxt;
  logic [LEN_W-1:0]  seq_len_nxt;
  logic [LEN_W-1:0]  addr_len;
  logic              wr_accept;
  color_t            mem     [SEQ_DEPTH];
  color_t            mem_nxt [SEQ_DEPTH];

  // Writes only land in IDLE; a clear in the same cycle takes priority.
  assign wr_accept = mem_write && (state == IDLE) && !clear;
  assign addr_len  = LEN_W'(mem_addr) + LEN_W'(1);

  // Busy is a pure decode of the state register, so it is glitch-free and
  // rises on the edge after clear is sampled.
  assign clear_busy = (state == SCRUB);
  assign seq_full   = (seq_len == FULL_LEN);

  // Scrub sequencing: any clear (re)starts the counter at entry 0; the pass
  // ends on the edge that zeroes entry 31.
  always_comb begin
    state_nxt     = state;
    scrub_cnt_nxt = scrub_cnt;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nxt     = SCRUB;
          scrub_cnt_nxt = '0;
        end
      end
      SCRUB: begin
        if (clear) begin
          scrub_cnt_nxt = '0;
        end else begin
          scrub_cnt_nxt = scrub_cnt + 1'b1;
          if (scrub_cnt == LAST_IDX) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt     = IDLE;
        scrub_cnt_nxt = '0;
      end
    endcase
  end

  // Next contents of the array: scrub zeroes one entry, or an accepted
  // write stores the colour. The read port samples this next view so a
  // same-cycle write to the read address is returned immediately.
  always_comb begin
    mem_nxt = mem;
    if (state == SCRUB)
      mem_nxt[scrub_cnt] = GREEN;
    else if (wr_accept)
      mem_nxt[mem_addr] = wr_data;
  end

  // Length tracks the highest written index + 1; cleared when a scrub starts.
  always_comb begin
    seq_len_nxt = seq_len;
    if (clear)
      seq_len_nxt = '0;
    else if (wr_accept && (addr_len > seq_len))
      seq_len_nxt = addr_len;
  end

  // All state: FSM, counter, length, storage and the read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      scrub_cnt <= '0;
      seq_len   <= '0;
      mem_data  <= GREEN;
      for (int i = 0; i < SEQ_DEPTH; i++) mem[i] <= GREEN;
    end else begin
      state     <= state_nxt;
      scrub_cnt <= scrub_cnt_nxt;
      seq_len   <= seq_len_nxt;
      mem       <= mem_nxt;
      mem_data  <= mem_nxt[mem_addr];
    end
  end

endmodule

// File: tb/tb_seq_memory.sv
// Self-checking bench for seq_memory: randomized writes/reads against an
// array-based reference, plus clear, restart and mid-scrub reset scenarios.
module tb_seq_memory;
  import simon_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_write;
  logic [4:0] mem_addr;
  color_t     wr_data;
  logic       clear;
  color_t     mem_data;
  logic [5:0] seq_len;
  logic       seq_full;
  logic       clear_busy;

  int     checks   = 0;
  int     failures = 0;
  color_t model_mem [32];
  int     model_len;

  seq_memory dut (
    .clk        (clk),
    .rst        (rst),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .wr_data    (wr_data),
    .clear      (clear),
    .mem_data   (mem_data),
    .seq_len    (seq_len),
    .seq_full   (seq_full),
    .clear_busy (clear_busy)
  );

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = GREEN;
    model_len = 0;
  endtask

  task automatic drive_write(input logic [4:0] a, input color_t d);
    mem_write = 1'b1; mem_addr = a; wr_data = d; clear = 1'b0;
    tick();
    mem_write = 1'b0;
    model_mem[a] = d;
    if (int'(a) + 1 > model_len) model_len = int'(a) + 1;
  endtask

  task automatic drive_read(input logic [4:0] a);
    mem_write = 1'b0; mem_addr = a; clear = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_write = 1'b0; clear = 1'b0; mem_addr = 5'd0; wr_data = GREEN;
    tick(); tick();
    checks++; if (mem_data !== GREEN) begin failures++; $display("FAIL reset_mem_data got %0d want 0", mem_data); end
    checks++; if (seq_len !== 6'd0) begin failures++; $display("FAIL reset_seq_len got %0d want 0", seq_len); end
    checks++; if (seq_full !== 1'b0) begin failures++; $display("FAIL reset_seq_full got %0b want 0", seq_full); end
    checks++; if (clear_busy !== 1'b0) begin failures++; $display("FAIL reset_clear_busy got %0b want 0", clear_busy); end
    rst = 1'b0;
    model_reset();
    // write on the very first edge after release
    drive_write(5'd0, YELLOW);
    checks++; if (mem_data !== YELLOW) begin failures++; $display("FAIL first_edge_write got %0d want 3", mem_data); end
    checks++; if (seq_len !== 6'd1) begin failures++; $display("FAIL first_edge_len got %0d want 1", seq_len); end
  endtask

  task automatic test_basic();
    drive_write(5'd0, RED);
    drive_write(5'd1, YELLOW);
    drive_read(5'd1);
    checks++; if (mem_data !== YELLOW) begin failures++; $display("FAIL basic_read1 got %0d want 3", mem_data); end
    checks++; if (seq_len !== 6'd2) begin failures++; $display("FAIL basic_len got %0d want 2", seq_len); end
    checks++; if (seq_full !== 1'b0) begin failures++; $display("FAIL basic_full got %0b want 0", seq_full); end
    drive_read(5'd0);
    checks++; if (mem_data !== RED) begin failures++; $display("FAIL basic_read0 got %0d want 1", mem_data); end
  endtask

  task automatic test_write_first();
    drive_write(5'd5, BLUE);
    checks++; if (mem_data !== BLUE) begin failures++; $display("FAIL write_first got %0d want 2", mem_data); end
    checks++; if (seq_len !== 6'd6) begin failures++; $display("FAIL write_first_len got %0d want 6", seq_len); end
  endtask

  task automatic test_random();
    logic [4:0] a;
    color_t     d;
    for (int n = 0; n < 60; n++) begin
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        d = color_t'($urandom_range(0, 3));
        drive_write(a, d);
        checks++; if (mem_data !== d) begin failures++; $display("FAIL rand_write a=%0d got %0d want %0d", a, mem_data, d); end
      end else begin
        drive_read(a);
        checks++; if (mem_data !== model_mem[a]) begin failures++; $display("FAIL rand_read a=%0d got %0d want %0d", a, mem_data, model_mem[a]); end
      end
      checks++; if (int'(seq_len) != model_len) begin failures++; $display("FAIL rand_len got %0d want %0d", seq_len, model_len); end
      checks++; if (seq_full !== (model_len == 32)) begin failures++; $display("FAIL rand_full got %0b want %0b", seq_full, model_len == 32); end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) drive_write(5'(i), color_t'($urandom_range(0, 3)));
    checks++; if (seq_len !== 6'd32) begin failures++; $display("FAIL fill_len got %0d want 32", seq_len); end
    checks++; if (seq_full !== 1'b1) begin failures++; $display("FAIL fill_full got %0b want 1", seq_full); end
    drive_write(5'd3, RED);
    checks++; if (seq_len !== 6'd32) begin failures++; $display("FAIL fill_sat_len got %0d want 32", seq_len); end
    checks++; if (mem_data !== RED) begin failures++; $display("FAIL fill_extra_write got %0d want 1", mem_data); end
    for (int i = 0; i < 32; i++) begin
      drive_read(5'(i));
      checks++; if (mem_data !== model_mem[i]) begin failures++; $display("FAIL fill_read a=%0d got %0d want %0d", i, mem_data, model_mem[i]); end
    end
  endtask

  task automatic test_clear();
    int busy_cnt;
    int guard;
    // clear collides with a write to 31: clear must win
    mem_write = 1'b1; mem_addr = 5'd31; wr_data = YELLOW; clear = 1'b1;
    tick();
    clear = 1'b0; mem_write = 1'b0;
    checks++; if (clear_busy !== 1'b1) begin failures++; $display("FAIL clear_busy_rise got %0b want 1", clear_busy); end
    checks++; if (seq_len !== 6'd0) begin failures++; $display("FAIL clear_len got %0d want 0", seq_len); end
    busy_cnt = 1;
    guard = 0;
    while (clear_busy === 1'b1 && guard < 200) begin
      mem_write = 1'b1;
      mem_addr  = 5'($urandom_range(0, 31));
      wr_data   = color_t'($urandom_range(1, 3));
      tick();
      guard++;
      if (clear_busy === 1'b1) busy_cnt++;
    end
    mem_write = 1'b0;
    checks++; if (busy_cnt != 32) begin failures++; $display("FAIL clear_busy_cycles got %0d want 32", busy_cnt); end
    checks++; if (seq_len !== 6'd0) begin failures++; $display("FAIL clear_len_after got %0d want 0", seq_len); end
    model_reset();
    for (int i = 0; i < 32; i++) begin
      drive_read(5'(i));
      checks++; if (mem_data !== GREEN) begin failures++; $display("FAIL clear_read a=%0d got %0d want 0", i, mem_data); end
    end
  endtask

  task automatic test_clear_restart();
    int busy_cnt;
    int guard;
    for (int i = 0; i < 8; i++) drive_write(5'(i), color_t'($urandom_range(1, 3)));
    clear = 1'b1; tick(); clear = 1'b0;
    busy_cnt = (clear_busy === 1'b1) ? 1 : 0;
    guard = 0;
    while (busy_cnt < 10 && guard < 50) begin
      tick(); guard++;
      if (clear_busy === 1'b1) busy_cnt++;
    end
    clear = 1'b1; tick(); clear = 1'b0;
    if (clear_busy === 1'b1) busy_cnt++;
    guard = 0;
    while (clear_busy === 1'b1 && guard < 200) begin
      tick(); guard++;
      if (clear_busy === 1'b1) busy_cnt++;
    end
    checks++; if (busy_cnt != 42) begin failures++; $display("FAIL restart_busy_cycles got %0d want 42", busy_cnt); end
    checks++; if (seq_len !== 6'd0) begin failures++; $display("FAIL restart_len got %0d want 0", seq_len); end
    model_reset();
    drive_read(5'd7);
    checks++; if (mem_data !== GREEN) begin failures++; $display("FAIL restart_read got %0d want 0", mem_data); end
  endtask

  task automatic test_reset_mid_scrub();
    int busy_cnt;
    int guard;
    for (int i = 0; i < 32; i++) drive_write(5'(i), color_t'($urandom_range(1, 3)));
    clear = 1'b1; tick(); clear = 1'b0;
    busy_cnt = (clear_busy === 1'b1) ? 1 : 0;
    guard = 0;
    while (busy_cnt < 15 && guard < 50) begin
      tick(); guard++;
      if (clear_busy === 1'b1) busy_cnt++;
    end
    rst = 1'b1;
    #1;
    checks++; if (clear_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %0b want 0", clear_busy); end
    checks++; if (seq_len !== 6'd0) begin failures++; $display("FAIL midrst_len got %0d want 0", seq_len); end
    checks++; if (mem_data !== GREEN) begin failures++; $display("FAIL midrst_mem_data got %0d want 0", mem_data); end
    tick();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 32; i++) begin
      drive_read(5'(i));
      checks++; if (mem_data !== GREEN) begin failures++; $display("FAIL midrst_read a=%0d got %0d want 0", i, mem_data); end
    end
    checks++; if (clear_busy !== 1'b0) begin failures++; $display("FAIL midrst_residual_busy got %0b want 0", clear_busy); end
    drive_write(5'd0, RED);
    drive_read(5'd0);
    checks++; if (mem_data !== RED) begin failures++; $display("FAIL midrst_readback got %0d want 1", mem_data); end
    checks++; if (seq_len !== 6'd1) begin failures++; $display("FAIL midrst_len_after got %0d want 1", seq_len); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_write_first();
    test_random();
    test_fill();
    test_clear();
    test_clear_restart();
    test_reset_mid_scrub();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_memory.md
SEQ_MEMORY -- requirements
Module: seq_memory

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  system clock, 50 MHz, all state on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 mem_write  input  1  write strobe from game FSM; one entry per cycle high.
REQ-005 mem_addr  input  5  entry index for write and read (0..31).
REQ-006 wr_data  input  2  colour to store (random_seq from LFSR).
REQ-007 clear  input  1  single-cycle pulse; start scrub of whole sequence.
REQ-008 mem_data  output  2  registered read data for mem_addr.
REQ-009 seq_len  output  6  number of stored entries (0..32).
REQ-010 seq_full  output  1  high when seq_len == 32.
REQ-011 clear_busy  output  1  high while scrub in progress.

Function
REQ-012 Storage SHALL be 32 entries x 2 bits, register-based, no vendor RAM.
REQ-013 Read SHALL be synchronous, 1-cycle latency: mem_data at edge N+1 = entry[mem_addr sampled at edge N].
REQ-014 Write SHALL occur at rising edge when mem_write=1 and clear_busy=0: entry[mem_addr] <= wr_data.
REQ-015 Same-cycle write and read of same address SHALL be write-first: mem_data next cycle = wr_data.
REQ-016 seq_len SHALL update on accepted write to max(seq_len, mem_addr+1); never decrements except by clear/reset.
REQ-017 Write to address 31 SHALL set seq_len=32 and seq_full=1 next cycle; further writes still accepted, seq_len saturates at 32.
REQ-018 seq_full SHALL be combinational decode of seq_len (seq_len == 32).
REQ-019 States: IDLE, SCRUB. IDLE->SCRUB on clear=1; SCRUB->IDLE after entry 31 written.
REQ-020 SCRUB SHALL write 2'b00 to one entry per cycle, index 0..31 via 5-bit scrub counter; exactly 32 cycles.
REQ-021 clear_busy SHALL be high in every SCRUB cycle, low in IDLE; registered (rises cycle after clear).
REQ-022 seq_len SHALL go to 0 on the edge that enters SCRUB.
REQ-023 mem_write during SCRUB SHALL be ignored (dropped, not queued); seq_len unchanged.
REQ-024 clear during SCRUB SHALL restart scrub counter at 0; total scrub extends to 32 cycles from latest clear.
REQ-025 clear and mem_write in same IDLE cycle: clear wins, write dropped.
REQ-026 Reads during SCRUB SHALL return current contents (scrubbed entries read 2'b00).

Reset
REQ-027 On rst: state=IDLE, scrub counter=0, seq_len=0, mem_data=2'b00, clear_busy=0, all 32 entries=2'b00.
REQ-028 rst asserted mid-SCRUB SHALL abort scrub immediately; IDLE after release, no residual busy.
REQ-029 Outputs SHALL be stable on first edge after rst deassertion; write accepted on that edge.

Structure
REQ-030 Shared package simon_pkg SHALL hold SEQ_DEPTH=32, ADDR_W=5, LEN_W=6, color_t (2-bit enum GREEN/RED/BLUE/YELLOW = 00/01/10/11).
REQ-031 seq_memory SHALL use color_t for storage and ports' colour fields; state enum local to module.
REQ-032 No sub-module; scrub counter and storage inline, target 120-200 lines.

Verification
REQ-033 Reset, write addr0=01, addr1=11; read addr1 -> mem_data=11 one cycle later, seq_len=2, seq_full=0.
REQ-034 Write addr5=10 with mem_addr held at 5 same cycle -> mem_data=10 next cycle (write-first); seq_len=6.
REQ-035 Write addrs 0..31 sequential -> seq_len=32, seq_full=1; extra write addr3 -> seq_len stays 32.
REQ-036 Fill, pulse clear -> clear_busy high for exactly 32 cycles, seq_len=0 next edge, all reads 00 after; mem_write during scrub leaves contents 00.
REQ-037 Pulse clear, second clear at scrub cycle 10 -> clear_busy high 42 cycles total from first clear.
REQ-038 Assert rst at scrub cycle 15 -> clear_busy=0, seq_len=0, all entries 00; write addr0=01 after release reads back 01.
